seg_scan_driver: RTL and testbench

- Multi-digit, time-multiplexed seven-segment display driver: decodes DIGITS 4-bit values and scans one digit at a time onto a shared a_g/dp bus with a per-digit select.
- Adds parametrised digit count, scan rate, optional hex decoding, per-digit blanking and decimal point, double-buffered tear-free updates, and anti-ghosting dead time.
- Sits between counter/clock logic and board display pins.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_hex_dec.sv | 34 +++
 rtl/seg_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are logical {a,b,c,d,e,f,g}, 1 = lit.
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_BAR = 7'b0000001;

    // Counter width for n states, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Four-bit value to logical seven-segment pattern.
// Without HEX_MODE, values 10..15 show only the middle bar.
module seg_hex_dec
    import seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BAR;
        unique case (val_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = (HEX_MODE != 0) ? SEG_A : SEG_BAR;
            4'hB: seg_o = (HEX_MODE != 0) ? SEG_B : SEG_BAR;
            4'hC: seg_o = (HEX_MODE != 0) ? SEG_C : SEG_BAR;
            4'hD: seg_o = (HEX_MODE != 0) ? SEG_D : SEG_BAR;
            4'hE: seg_o = (HEX_MODE != 0) ? SEG_E : SEG_BAR;
            4'hF: seg_o = (HEX_MODE != 0) ? SEG_F : SEG_BAR;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered digits
// and an anti-ghosting dead time at the start of every digit slot.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int DEAD         = 2,
    parameter int HEX_MODE     = 0,
    parameter int SEG_ACT_HIGH = 1,
    parameter int SEL_ACT_HIGH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [6:0]            a_g,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int IDX_W = clog2(DIGITS);
    localparam int PRE_W = clog2(CLK_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] DEAD_CNT = PRE_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [6:0]        SEG_OFF = (SEG_ACT_HIGH != 0) ? 7'h00 : 7'h7F;
    localparam logic              DP_OFF  = (SEG_ACT_HIGH != 0) ? 1'b0 : 1'b1;
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACT_HIGH != 0) ? '0 : '1;

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_num_q, sh_num_d, pn_num_q, pn_num_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, pn_dp_q, pn_dp_d;
    logic [DIGITS-1:0]   sh_bl_q, sh_bl_d, pn_bl_q, pn_bl_d;
    logic                pflag_q, pflag_d;
    logic [6:0]          a_g_q, a_g_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                fd_q;

    logic                tc, bnd, lit;
    logic [3:0]          cur_num;
    logic                cur_dp, cur_bl;
    logic [DIGITS-1:0]   cur_oh;
    logic [6:0]          dec_seg, seg_log;
    logic                dp_log;
    logic [DIGITS-1:0]   sel_log;

    assign tc  = (presc_q == PRE_LAST);
    assign bnd = tc && (idx_q == IDX_LAST);

    always_comb begin
        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Shadow only moves at the frame boundary; a load landing on the
    // boundary bypasses pending so it is never shown a frame late.
    always_comb begin
        sh_num_d = sh_num_q;
        sh_dp_d  = sh_dp_q;
        sh_bl_d  = sh_bl_q;
        pn_num_d = pn_num_q;
        pn_dp_d  = pn_dp_q;
        pn_bl_d  = pn_bl_q;
        pflag_d  = pflag_q;
        if (bnd) begin
            if (load) begin
                sh_num_d = num;
                sh_dp_d  = dp_in;
                sh_bl_d  = blank;
            end else if (pflag_q) begin
                sh_num_d = pn_num_q;
                sh_dp_d  = pn_dp_q;
                sh_bl_d  = pn_bl_q;
            end
            pflag_d = 1'b0;
        end else if (load) begin
            pn_num_d = num;
            pn_dp_d  = dp_in;
            pn_bl_d  = blank;
            pflag_d  = 1'b1;
        end
    end

    always_comb begin
        cur_num = 4'h0;
        cur_dp  = 1'b0;
        cur_bl  = 1'b0;
        cur_oh  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_num   = sh_num_q[4*i +: 4];
                cur_dp    = sh_dp_q[i];
                cur_bl    = sh_bl_q[i];
                cur_oh[i] = 1'b1;
            end
        end
    end

    seg_hex_dec #(
        .HEX_MODE (HEX_MODE)
    ) u_dec (
        .val_i (cur_num),
        .seg_o (dec_seg)
    );

    always_comb begin
        lit     = (presc_q >= DEAD_CNT) && !cur_bl;
        seg_log = lit ? dec_seg : 7'h00;
        dp_log  = lit && cur_dp;
        sel_log = lit ? cur_oh : '0;
        a_g_d   = (SEG_ACT_HIGH != 0) ? seg_log : ~seg_log;
        dp_d    = (SEG_ACT_HIGH != 0) ? dp_log : ~dp_log;
        sel_d   = (SEL_ACT_HIGH != 0) ? sel_log : ~sel_log;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            sh_num_q <= '0;
            sh_dp_q  <= '0;
            sh_bl_q  <= '0;
            pn_num_q <= '0;
            pn_dp_q  <= '0;
            pn_bl_q  <= '0;
            pflag_q  <= 1'b0;
            a_g_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            sel_q    <= SEL_OFF;
            fd_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            sh_num_q <= sh_num_d;
            sh_dp_q  <= sh_dp_d;
            sh_bl_q  <= sh_bl_d;
            pn_num_q <= pn_num_d;
            pn_dp_q  <= pn_dp_d;
            pn_bl_q  <= pn_bl_d;
            pflag_q  <= pflag_d;
            a_g_q    <= a_g_d;
            dp_q     <= dp_d;
            sel_q    <= sel_d;
            fd_q     <= bnd;
        end
    end

    assign a_g        = a_g_q;
    assign dp         = dp_q;
    assign sel        = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances with opposite
// polarities and decode modes checked against a slot-arithmetic model.
module tb_seg_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int DEAD    = 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] num;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        load;

    logic [6:0]  a0, a1;
    logic        dp0, dp1;
    logic [3:0]  sel0, sel1;
    logic        fd0, fd1;

    seg_scan_driver #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD),
        .HEX_MODE(0), .SEG_ACT_HIGH(1), .SEL_ACT_HIGH(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .num(num), .dp_in(dp_in),
        .blank(blank), .load(load), .a_g(a0), .dp(dp0),
        .sel(sel0), .frame_done(fd0)
    );

    seg_scan_driver #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD),
        .HEX_MODE(1), .SEG_ACT_HIGH(0), .SEL_ACT_HIGH(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .num(num), .dp_in(dp_in),
        .blank(blank), .load(load), .a_g(a1), .dp(dp1),
        .sel(sel1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [25:0] q[$];

    // Reference state: cycles since reset plus the displayed/pending frames.
    int          t = 0;
    logic [15:0] m_num = '0, p_num = '0;
    logic [3:0]  m_dp = '0, p_dp = '0;
    logic [3:0]  m_bl = '0, p_bl = '0;
    bit          p_flag = 0;

    function automatic logic [6:0] ref_dec(input logic [3:0] v, input bit hex);
        case (v)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            4'd10: return hex ? 7'b1110111 : 7'b0000001;
            4'd11: return hex ? 7'b0011111 : 7'b0000001;
            4'd12: return hex ? 7'b1001110 : 7'b0000001;
            4'd13: return hex ? 7'b0111101 : 7'b0000001;
            4'd14: return hex ? 7'b1001111 : 7'b0000001;
            default: return hex ? 7'b1000111 : 7'b0000001;
        endcase
    endfunction

    function automatic logic [12:0] pins(input logic [3:0] v, input bit lit,
                                         input bit dpv, input int d, input bit fd,
                                         input bit hex, input bit sp, input bit lp);
        logic [6:0] s;
        logic       p;
        logic [3:0] e;
        s = lit ? ref_dec(v, hex) : 7'h00;
        p = lit & dpv;
        e = lit ? (4'b0001 << d) : 4'b0000;
        if (!sp) begin
            s = ~s;
            p = ~p;
        end
        if (!lp) e = ~e;
        return {s, p, e, fd};
    endfunction

    task automatic model_edge();
        int         pos, d;
        bit         bnd, lit;
        logic [3:0] v;
        if (!rst_n) begin
            q.push_back({pins(4'h0, 0, 0, 0, 0, 0, 1, 0),
                         pins(4'h0, 0, 0, 0, 0, 1, 0, 1)});
            t = 0;
            m_num = '0; m_dp = '0; m_bl = '0;
            p_num = '0; p_dp = '0; p_bl = '0;
            p_flag = 0;
        end else begin
            pos = t % CLK_DIV;
            d   = (t / CLK_DIV) % DIGITS;
            bnd = (pos == CLK_DIV - 1) && (d == DIGITS - 1);
            v   = m_num[d*4 +: 4];
            lit = (pos >= DEAD) && !m_bl[d];
            q.push_back({pins(v, lit, m_dp[d], d, bnd, 0, 1, 0),
                         pins(v, lit, m_dp[d], d, bnd, 1, 0, 1)});
            if (bnd) begin
                if (load) begin
                    m_num = num; m_dp = dp_in; m_bl = blank;
                end else if (p_flag) begin
                    m_num = p_num; m_dp = p_dp; m_bl = p_bl;
                end
                p_flag = 0;
            end else if (load) begin
                p_num = num; p_dp = dp_in; p_bl = blank;
                p_flag = 1;
            end
            t++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic run_to(input int ph);
        for (int k = 0; k < 64 && (t % 16) != ph; k++) step();
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [25:0] e;
            e = q.pop_front();
            tests++;
            if ({a0, dp0, sel0, fd0} !== e[25:13]) begin
                fails++;
                $display("FAIL u0 cyc=%0d got a_g=%b dp=%b sel=%b fd=%b want a_g=%b dp=%b sel=%b fd=%b",
                         cyc, a0, dp0, sel0, fd0,
                         e[25:19], e[18], e[17:14], e[13]);
            end
            tests++;
            if ({a1, dp1, sel1, fd1} !== e[12:0]) begin
                fails++;
                $display("FAIL u1 cyc=%0d got a_g=%b dp=%b sel=%b fd=%b want a_g=%b dp=%b sel=%b fd=%b",
                         cyc, a1, dp1, sel1, fd1,
                         e[12:6], e[5], e[4:1], e[0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; num = '0; dp_in = '0; blank = '0;
        step(); step();
        rst_n = 1'b1;

        // First frame shows zeros, then 4321 from the boundary on.
        load = 1'b1; num = 16'h4321;
        step();
        load = 1'b0;
        repeat (40) step();

        // Two loads in one frame: only the second one is ever shown.
        run_to(3);
        load = 1'b1; num = 16'h1111;
        step();
        load = 1'b0;
        run_to(9);
        load = 1'b1; num = 16'hABCD; dp_in = 4'b0001; blank = 4'b0100;
        step();
        load = 1'b0; dp_in = '0; blank = '0;
        repeat (40) step();

        // Stale pending must not survive a load landing on the boundary.
        run_to(5);
        load = 1'b1; num = 16'h9876;
        step();
        load = 1'b0;
        run_to(15);
        load = 1'b1; num = 16'h5E0F; dp_in = 4'b1010;
        step();
        load = 1'b0; dp_in = '0;
        repeat (40) step();

        // Reset in the middle of the digit-2 slot.
        run_to(10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (24) step();

        for (int n = 0; n < 700; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            load  = ($urandom_range(0, 9) == 0);
            num   = 16'($urandom);
            dp_in = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step();
        end
        rst_n = 1'b1; load = 1'b0;
        repeat (20) step();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
